// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog: fractional baud generator, oversample/bit enables, valid/ready rate reload, hold re-phase
module uart_baud_gen_prog #(
  parameter int CLOCK_SPEED = 2000000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int HOLD_PHASE  = 0,
  parameter int BAUD_WIDTH  = 24,
  parameter int DELAY       = 0
) (
  input  logic                  uart_clk,
  input  logic                  uart_rstn,
  input  logic                  uart_hold,
  input  logic [BAUD_WIDTH-1:0] cfg_baud,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [BAUD_WIDTH-1:0] cur_baud,
  output logic                  uart_os_ena,
  output logic                  uart_ena
);
  localparam int ACC_W = $clog2(CLOCK_SPEED) + 1;
  localparam int INC_W = BAUD_WIDTH + $clog2(OVERSAMPLE);
  localparam int SUM_W = (ACC_W > INC_W ? ACC_W : INC_W) + 1;
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [SUM_W-1:0] MOD = SUM_W'(CLOCK_SPEED);
  localparam logic [INC_W-1:0] RST_INC = INC_W'(BAUD_RATE * OVERSAMPLE);
  localparam logic [OS_W-1:0] LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] PHASE = OS_W'(HOLD_PHASE);
  if (BAUD_RATE == 0 || OVERSAMPLE < 2 || BAUD_RATE * OVERSAMPLE > CLOCK_SPEED) begin : g_bad_params
    $error("uart_baud_gen_prog: invalid CLOCK_SPEED/BAUD_RATE/OVERSAMPLE");
  end
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [INC_W-1:0] inc_q, inc_d, pend_inc_q, pend_inc_d, cfg_inc;
  logic [BAUD_WIDTH-1:0] cur_baud_q, cur_baud_d, pend_baud_q, pend_baud_d;
  logic pending_q, pending_d, cfg_err_q, cfg_err_d;
  logic [DELAY:0] os_pipe_q, os_pipe_d, bit_pipe_q, bit_pipe_d;
  logic [SUM_W-1:0] sum;
  logic os_ev, bit_ev, apply, take;
  always_comb begin
    sum = SUM_W'(acc_q) + SUM_W'(inc_q);
    os_ev = !uart_hold && sum >= MOD;
    bit_ev = os_ev && os_cnt_q == LAST;
    apply = pending_q && (uart_hold || bit_ev);
    cfg_inc = INC_W'(cfg_baud) * INC_W'(OVERSAMPLE);
    cfg_err_d = cfg_valid && !pending_q && (cfg_baud == '0 || SUM_W'(cfg_inc) > MOD);
    take = cfg_valid && !pending_q && !cfg_err_d;
    acc_d = (uart_hold || apply) ? '0 : ACC_W'(os_ev ? sum - MOD : sum);
    os_cnt_d = uart_hold ? PHASE : !os_ev ? os_cnt_q : bit_ev ? '0 : os_cnt_q + 1'b1;
    inc_d = apply ? pend_inc_q : inc_q;
    cur_baud_d = apply ? pend_baud_q : cur_baud_q;
    pending_d = apply ? 1'b0 : take ? 1'b1 : pending_q;
    pend_inc_d = take ? cfg_inc : pend_inc_q;
    pend_baud_d = take ? cfg_baud : pend_baud_q;
    os_pipe_d = os_pipe_q << 1;
    os_pipe_d[0] = os_ev;
    bit_pipe_d = bit_pipe_q << 1;
    bit_pipe_d[0] = bit_ev;
  end
  always_ff @(posedge uart_clk or negedge uart_rstn) begin
    if (!uart_rstn) begin
      acc_q <= '0;
      os_cnt_q <= PHASE;
      inc_q <= RST_INC;
      cur_baud_q <= BAUD_WIDTH'(BAUD_RATE);
      pend_inc_q <= '0;
      pend_baud_q <= '0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
      os_pipe_q <= '0;
      bit_pipe_q <= '0;
    end else begin
      acc_q <= acc_d;
      os_cnt_q <= os_cnt_d;
      inc_q <= inc_d;
      cur_baud_q <= cur_baud_d;
      pend_inc_q <= pend_inc_d;
      pend_baud_q <= pend_baud_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
      os_pipe_q <= os_pipe_d;
      bit_pipe_q <= bit_pipe_d;
    end
  end
  assign cfg_ready = !pending_q;
  assign cfg_err = cfg_err_q;
  assign cur_baud = cur_baud_q;
  assign uart_os_ena = os_pipe_q[DELAY];
  assign uart_ena = bit_pipe_q[DELAY];
endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// tb_uart_baud_gen_prog: directed checks of rate, hold, config, delay and reset behaviour
module tb_uart_baud_gen_prog;
  logic clk = 0;
  logic rstn = 0;
  logic hold2 = 0;
  logic valid0 = 0;
  logic [23:0] baud0 = '0;
  logic os[4], ena[4], rdy[4], err[4];
  logic [23:0] cur[4];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit u1_done = 0;
  always #5 clk = ~clk;
  uart_baud_gen_prog #(.CLOCK_SPEED(1600), .BAUD_RATE(100)) u0 (
    .uart_clk(clk), .uart_rstn(rstn), .uart_hold(1'b0), .cfg_baud(baud0), .cfg_valid(valid0),
    .cfg_ready(rdy[0]), .cfg_err(err[0]), .cur_baud(cur[0]), .uart_os_ena(os[0]), .uart_ena(ena[0]));
  uart_baud_gen_prog u1 (
    .uart_clk(clk), .uart_rstn(rstn), .uart_hold(1'b0), .cfg_baud(24'd0), .cfg_valid(1'b0),
    .cfg_ready(rdy[1]), .cfg_err(err[1]), .cur_baud(cur[1]), .uart_os_ena(os[1]), .uart_ena(ena[1]));
  uart_baud_gen_prog #(.CLOCK_SPEED(1600), .BAUD_RATE(100), .HOLD_PHASE(8)) u2 (
    .uart_clk(clk), .uart_rstn(rstn), .uart_hold(hold2), .cfg_baud(24'd0), .cfg_valid(1'b0),
    .cfg_ready(rdy[2]), .cfg_err(err[2]), .cur_baud(cur[2]), .uart_os_ena(os[2]), .uart_ena(ena[2]));
  uart_baud_gen_prog #(.CLOCK_SPEED(1600), .BAUD_RATE(100), .DELAY(3)) u3 (
    .uart_clk(clk), .uart_rstn(rstn), .uart_hold(1'b0), .cfg_baud(24'd0), .cfg_valid(1'b0),
    .cfg_ready(rdy[3]), .cfg_err(err[3]), .cur_baud(cur[3]), .uart_os_ena(os[3]), .uart_ena(ena[3]));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    int n_os, last, bad_gap, n_ena;
    n_os = 0;
    n_ena = 0;
    last = -1;
    bad_gap = 0;
    @(posedge rstn);
    for (int i = 1; i <= 10000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (os[1]) begin
        if (last >= 0 && i - last > 2) bad_gap++;
        last = i;
        n_os++;
      end
      if (ena[1]) n_ena++;
    end
    check("default_os_count", n_os, 9216);
    check("default_ena_count", n_ena, 576);
    check("default_os_spacing", bad_gap, 0);
    u1_done = 1;
  end
  initial begin
    int n_os0, n_os3, n_ena0, n_ena3, f_os3, f_ena0, f_ena3, f_ena2, s_ena2, n_os2, quiet;
    int bad_vals[3];
    bad_vals = '{200, 0, 101};
    n_os0 = 0; n_os3 = 0; n_ena0 = 0; n_ena3 = 0; f_os3 = 0; f_ena0 = 0; f_ena3 = 0; f_ena2 = 0;
    repeat (3) @(negedge clk);
    check("rst_os_ena", os[0], 0);
    check("rst_ena", ena[0], 0);
    check("rst_cur_baud", cur[0], 100);
    check("rst_cfg_ready", rdy[0], 1);
    check("rst_cfg_err", err[0], 0);
    check("rst_cur_baud_default", cur[1], 115200);
    rstn = 1;
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (os[0]) n_os0++;
      if (os[3]) n_os3++;
      if (os[3] && f_os3 == 0) f_os3 = k;
      if (ena[0]) n_ena0++;
      if (ena[0] && f_ena0 == 0) f_ena0 = k;
      if (ena[3]) n_ena3++;
      if (ena[3] && f_ena3 == 0) f_ena3 = k;
      if (ena[2] && f_ena2 == 0) f_ena2 = k;
    end
    check("full_rate_os_count", n_os0, 40);
    check("full_rate_first_ena", f_ena0, 16);
    check("full_rate_ena_count", n_ena0, 2);
    check("delay_first_os", f_os3, 4);
    check("delay_os_count", n_os3, 37);
    check("delay_first_ena", f_ena3, 19);
    check("delay_ena_count", n_ena3, 2);
    check("phase8_first_ena_after_reset", f_ena2, 8);
    hold2 = 1;
    quiet = 0;
    repeat (5) begin
      step();
      if (os[2] || ena[2]) quiet++;
    end
    check("hold_no_pulses", quiet, 0);
    hold2 = 0;
    f_ena2 = 0; s_ena2 = 0; n_os2 = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (os[2]) n_os2++;
      if (ena[2] && f_ena2 != 0 && s_ena2 == 0) s_ena2 = k;
      if (ena[2] && f_ena2 == 0) f_ena2 = k;
    end
    check("hold_release_first_ena", f_ena2, 8);
    check("hold_release_second_ena", s_ena2, 24);
    check("hold_release_os_count", n_os2, 24);
    while (cyc % 16 != 5) step();
    baud0 = 50;
    valid0 = 1;
    step();
    valid0 = 0;
    check("cfg_accept_ready_low", rdy[0], 0);
    check("cfg_accept_cur_unchanged", cur[0], 100);
    while (cyc % 16 != 15) step();
    check("cfg_pending_ready_low", rdy[0], 0);
    check("cfg_pending_cur_old", cur[0], 100);
    step();
    check("cfg_apply_ena", ena[0], 1);
    check("cfg_apply_cur", cur[0], 50);
    check("cfg_apply_ready", rdy[0], 1);
    n_os0 = 0; n_ena0 = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (os[0]) n_os0++;
      if (ena[0]) n_ena0++;
    end
    check("half_rate_os_count", n_os0, 16);
    check("half_rate_ena_count", n_ena0, 1);
    check("half_rate_ena_at_32", ena[0], 1);
    foreach (bad_vals[i]) begin
      baud0 = 24'(bad_vals[i]);
      valid0 = 1;
      step();
      valid0 = 0;
      check($sformatf("cfg_err_%0d", bad_vals[i]), err[0], 1);
      check($sformatf("cfg_err_ready_%0d", bad_vals[i]), rdy[0], 1);
      step();
      check($sformatf("cfg_err_pulse_%0d", bad_vals[i]), err[0], 0);
    end
    check("cfg_err_cur_unchanged", cur[0], 50);
    wait (u1_done);
    @(negedge clk);
    baud0 = 80;
    valid0 = 1;
    step();
    valid0 = 0;
    check("pre_reset_pending", rdy[0], 0);
    check("pre_reset_delay_os", os[3], 1);
    #2 rstn = 0;
    #1;
    check("async_rst_delay_os", os[3], 0);
    check("async_rst_ena", ena[0], 0);
    check("async_rst_cur_baud", cur[0], 100);
    check("async_rst_ready", rdy[0], 1);
    @(negedge clk);
    rstn = 1;
    n_os0 = 0; f_ena0 = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (os[0]) n_os0++;
      if (ena[0] && f_ena0 == 0) f_ena0 = k;
    end
    check("post_rst_os_count", n_os0, 16);
    check("post_rst_first_ena", f_ena0, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen_prog.md
Name: uart_baud_gen_prog

Overview:
Runtime-programmable fractional baud generator with an oversample tick. It is the successor to the fixed-rate baud enable used by the UART TX and RX cores. It emits an oversample enable (OVERSAMPLE x baud) and a bit enable (1 x baud). The rate is reloadable through a valid/ready config port, and the update is applied glitch-free at a bit boundary. A hold input re-phases the generator so RX can align sampling to mid-bit.

Parameters:
CLOCK_SPEED, 2000000, uart_clk frequency in Hz; modulus of the phase accumulator.
BAUD_RATE, 115200, baud rate loaded at reset.
OVERSAMPLE, 16, oversample ticks per bit; must be >= 2.
HOLD_PHASE, 0, os_cnt value forced during hold. Use 0 for TX (full bit to first uart_ena). Use OVERSAMPLE/2 for RX (half bit).
BAUD_WIDTH, 24, width of cfg_baud / cur_baud.
DELAY, 0, extra register stages on uart_ena and uart_os_ena. The two enables stay phase-aligned.

Ports:
uart_clk  in  1  clock
uart_rstn  in  1  asynchronous, active-low reset
uart_hold  in  1  1 = freeze and re-phase generator
cfg_baud  in  BAUD_WIDTH  requested baud rate
cfg_valid  in  1  config request
cfg_ready  out  1  config port can accept
cfg_err  out  1  one-cycle pulse: request rejected
cur_baud  out  BAUD_WIDTH  baud rate currently in effect
uart_os_ena  out  1  oversample enable pulse
uart_ena  out  1  bit enable pulse

Behaviour:
- Elaboration error if BAUD_RATE*OVERSAMPLE > CLOCK_SPEED, BAUD_RATE == 0, or OVERSAMPLE < 2.
- Widths:
  - acc is clog2(CLOCK_SPEED)+1 bits.
  - inc = baud*OVERSAMPLE is BAUD_WIDTH+clog2(OVERSAMPLE) bits.
  - The sum acc+inc is computed one bit wider and never truncated.
- Reset values: acc=0, os_cnt=HOLD_PHASE, inc=BAUD_RATE*OVERSAMPLE, cur_baud=BAUD_RATE, pending=0, cfg_ready=1, cfg_err=0, uart_os_ena=0, uart_ena=0, all delay stages 0.
- Accumulator, per cycle, when uart_hold=0:
  - If acc+inc >= CLOCK_SPEED: acc <= acc+inc-CLOCK_SPEED, and an os event occurs.
  - Otherwise acc <= acc+inc.
- os_cnt increments on each os event and wraps from OVERSAMPLE-1 to 0. An os event at os_cnt==OVERSAMPLE-1 is also a bit event.
- Output registration:
  - uart_os_ena <= os event; uart_ena <= bit event. Both are registered, 1 cycle after the event cycle, plus DELAY cycles.
  - Both are single-cycle pulses.
  - With inc==CLOCK_SPEED, uart_os_ena is high continuously.
- Hold, while uart_hold=1:
  - acc <= 0, os_cnt <= HOLD_PHASE; no events occur.
  - The registered outputs are 0 from the first edge after hold rises. Pulses already in the delay line still drain.
  - After hold is released, the first uart_ena comes after exactly OVERSAMPLE-HOLD_PHASE os events.
- Config acceptance:
  - Handshake when cfg_valid && cfg_ready.
  - If cfg_baud==0 or cfg_baud*OVERSAMPLE > CLOCK_SPEED, then cfg_err=1 for one cycle and nothing else changes. cfg_ready stays 1.
  - Otherwise latch pend_inc, set pending=1, and drop cfg_ready to 0.
- Config apply happens in a cycle with pending=1 and either (uart_hold=1) or (a bit event):
  - inc <= pend_inc, cur_baud updated, acc <= 0, pending=0, cfg_ready <= 1 on the next edge.
  - The bit event in that cycle is still output.
  - The new rate governs from the next cycle.
- Simultaneous events:
  - A request accepted in the same cycle as a bit event is applied at the next bit boundary, not the current one.
  - Apply and hold in the same cycle: the hold values win for acc and os_cnt.
- Reset asserted mid-operation clears everything immediately (asynchronous), including pending config and delay stages. Deassertion is synchronised by the integrator.

Test Plan:
- CLOCK_SPEED=1600, BAUD_RATE=100, OVERSAMPLE=16, HOLD_PHASE=0, DELAY=0; release reset -> uart_os_ena high every cycle, uart_ena pulses every 16 cycles, first uart_ena on the 16th cycle after reset release.
- Defaults (2000000, 115200, 16); run 10000 cycles from reset -> exactly 9216 uart_os_ena and 576 uart_ena pulses, with uart_os_ena spacing only 1 or 2 cycles.
- CLOCK_SPEED=1600, HOLD_PHASE=8; hold 5 cycles then release -> no pulses while held, first uart_ena on the 8th cycle after release, then every 16.
- Request cfg_baud=50 mid-bit -> cfg_ready=0 until the next uart_ena, cur_baud=50 after it, then uart_ena period 32 cycles. Request cfg_baud=200 (3200>1600) -> one-cycle cfg_err, cur_baud unchanged, cfg_ready stays 1.
- DELAY=3 -> both enables shifted by exactly 3 cycles versus the DELAY=0 reference, same pulse counts.
- Assert uart_rstn low mid-bit with a pending config -> all outputs 0 immediately, cur_baud=BAUD_RATE, cfg_ready=1, os_cnt restarts.
